// File: rtl/bcd_converter_pkg.sv
// bcd_converter_pkg: shared state encoding and double-dabble adjust constants
package bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 correction of one BCD digit ahead of a double-dabble shift
module bcd_digit_adj
    import bcd_converter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // A digit of 5 or more would reach 10+ after the shift, so pre-bias it by 3
    always_comb begin
        digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_VAL : digit_i;
    end

endmodule

// File: rtl/bcd_converter.sv
// bcd_converter: sequential binary-to-BCD converter, one shift per clock, output held between conversions
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_digits_check
        $error("bcd_converter: DIGITS too small for WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [SW-1:0]    scr_q, scr_d;
    logic [SW-1:0]    scr_adj;
    logic [SW-1:0]    bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scr_q[4*i +: 4]),
            .digit_o (scr_adj[4*i +: 4])
        );
    end

    // Next-state and datapath: capture on request, adjust-then-shift, publish in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        cap_d   = cap_q;
        last_d  = last_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (start || bin != last_q) begin
                    state_d = SHIFT;
                    shreg_d = bin;
                    cap_d   = bin;
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH);
                end
            end
            SHIFT: begin
                {scr_d, shreg_d} = {scr_adj, shreg_q} << 1;
                cnt_d            = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = scr_q;
                last_d  = cap_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            cap_q   <= '0;
            last_q  <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            cap_q   <= cap_d;
            last_q  <= last_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: directed vector bench for the sequential binary-to-BCD converter
module tb_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bin;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[12];

    bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .bin   (bin),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: got no done expected done within 20 cycles", name);
        end
    endtask

    initial begin
        int early;
        int dones;
        logic [11:0] e;

        vecs[0]  = '{8'd9,   12'h009};
        vecs[1]  = '{8'd10,  12'h010};
        vecs[2]  = '{8'd99,  12'h099};
        vecs[3]  = '{8'd100, 12'h100};
        vecs[4]  = '{8'd199, 12'h199};
        vecs[5]  = '{8'd200, 12'h200};
        vecs[6]  = '{8'd254, 12'h254};
        vecs[7]  = '{8'd255, 12'h255};
        vecs[8]  = '{8'd0,   12'h000};
        vecs[9]  = '{8'd1,   12'h001};
        vecs[10] = '{8'd128, 12'h128};
        vecs[11] = '{8'd63,  12'h063};

        rst = 1'b0; bin = 8'd0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset bcd", 32'(bcd), 32'h000);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        rst = 1'b1;

        // 1: idle with bin=0 never converts
        early = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) early++;
        end
        check("idle no activity", 32'(early), 0);
        check("idle bcd", 32'(bcd), 32'h000);

        // 2: latency of 0 -> 255
        bin = 8'd255;
        early = 0;
        @(negedge clk);
        check("t2 busy after request", 32'(busy), 1);
        if (done || bcd != 12'h000) early++;
        repeat (8) begin
            @(negedge clk);
            if (done || bcd != 12'h000) early++;
        end
        check("t2 no early update", 32'(early), 0);
        @(negedge clk);
        check("t2 done at k+9", 32'(done), 1);
        check("t2 bcd 255", 32'(bcd), 32'h255);

        // directed table
        for (int i = 0; i < 12; i++) begin
            bin = vecs[i].bin;
            wait_done($sformatf("vec%0d done", i));
            check($sformatf("vec%0d bin=%0d", i, vecs[i].bin), 32'(bcd), 32'(vecs[i].exp));
        end

        // 3: full sweep against decimal digits
        for (int v = 0; v < 256; v++) begin
            bin = 8'(v);
            wait_done($sformatf("sweep %0d done", v));
            e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            check($sformatf("sweep %0d", v), 32'(bcd), 32'(e));
        end

        // 4: bin change mid-conversion retriggers afterwards
        @(negedge clk);
        bin = 8'd42;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bin = 8'd200;
        wait_done("t4 first done");
        check("t4 first bcd", 32'(bcd), 32'h042);
        wait_done("t4 second done");
        check("t4 second bcd", 32'(bcd), 32'h200);

        // 5: async reset mid-SHIFT
        @(negedge clk);
        bin = 8'd137;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5 async bcd", 32'(bcd), 32'h000);
        check("t5 async busy", 32'(busy), 0);
        check("t5 async done", 32'(done), 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b1;
        early = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) dones++;
            if (bcd != 12'h000) early++;
        end
        check("t5 no done during/after reset", 32'(dones), 0);
        check("t5 no early bcd", 32'(early), 0);
        @(negedge clk);
        check("t5 done after 10", 32'(done), 1);
        check("t5 bcd 137", 32'(bcd), 32'h137);

        // 6: start forces conversion of unchanged bin; start while busy ignored
        @(negedge clk);
        bin = 8'd7;
        wait_done("t6 setup done");
        check("t6 setup bcd", 32'(bcd), 32'h007);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6 busy after start", 32'(busy), 1);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
        end
        check("t6 single done", 32'(dones), 1);
        check("t6 bcd 007", 32'(bcd), 32'h007);

        // start and bin change together: one conversion
        bin = 8'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6 start+change single done", 32'(dones), 1);
        check("t6 bcd 008", 32'(bcd), 32'h008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
